gate_exerciser: RTL and testbench

Sequential stimulus driver and response checker for the single-output combinational gates in the basic-gates library. It walks every input vector into a gate under test and samples the gate output after a programmable settle time. It compares each sample against the selected gate function and reports pass/fail, an error count and the first failing vector. It is the initiating end of the gate interface: the gates are pure responders and this block drives their inputs and reads their output.

---
 rtl/gate_exerciser.sv | 155 +++++++++++++++
 tb/tb_gate_exerciser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_exerciser.sv
// gate_exerciser: walks every input vector into a combinational gate under
// test, samples its output after a programmable settle time, and reports
// pass/fail, a mismatch count and the first failing vector.
module gate_exerciser #(
  parameter int N_IN   = 2,  // gate input width, 1..4
  parameter int SETTLE = 1   // extra hold cycles per vector, 0..15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e          state_q;
  op_e             op_q;
  logic [N_IN-1:0] vec_q;
  logic [3:0]      settle_q;
  logic [N_IN-1:0] dut_in_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_cnt_q;
  logic [N_IN-1:0] fail_vec_q;

  logic            expected;
  logic            mismatch;
  logic [N_IN:0]   err_cnt_d;
  logic [N_IN-1:0] fail_vec_d;

  // Reference value of the selected gate function for the current vector.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    expected = 1'b0;
    case (op_q)
      OP_NOT:  expected = ~vec_q[0];
      OP_BUF:  expected = vec_q[0];
      OP_AND:  expected = &vec_q;
      OP_NAND: expected = ~(&vec_q);
      OP_OR:   expected = |vec_q;
      OP_NOR:  expected = ~(|vec_q);
      OP_XOR:  expected = ^vec_q;
      OP_XNOR: expected = ~(^vec_q);
      default: expected = 1'b0;
    endcase
  end

  // Error bookkeeping as it would stand after a sample of the current vector.
  always_comb begin
    mismatch   = (dut_out != expected);
    err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, mismatch};
    fail_vec_d = (mismatch && (err_cnt_q == '0)) ? vec_q : fail_vec_q;
  end

  // Run sequencer: vector walk, settle timing, sampling and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state_q    <= S_IDLE;
      op_q       <= OP_NOT;
      vec_q      <= '0;
      settle_q   <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // start beats a simultaneous abort: abort is meaningless outside RUN
          if (start) begin
            state_q    <= S_RUN;
            op_q       <= op_e'(op);
            vec_q      <= '0;
            settle_q   <= '0;
            dut_in_q   <= '0;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            // partial err_cnt/fail_vec are kept for inspection; pass stays 0
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            dut_in_q <= '0;
          end else if (settle_q == SETTLE_C) begin
            settle_q   <= '0;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
            if (vec_q == VEC_LAST) begin
              // vec is left at its last value so it never wraps while in RUN
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              pass_q   <= (err_cnt_d == '0);
              dut_in_q <= '0;
            end else begin
              vec_q    <= vec_q + 1'b1;
              dut_in_q <= vec_q + 1'b1;
            end
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: drives two exerciser instances (N_IN=2/SETTLE=1 and
// N_IN=3/SETTLE=0) against behavioural gate models; a scoreboard queue holds
// the run results predicted at start and compares them when done pulses.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // instance A: N_IN=2, SETTLE=1
  logic       start_a, abort_a;
  logic [2:0] op_a;
  logic [1:0] din_a;
  logic       dout_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [1:0] fv_a;
  // instance B: N_IN=3, SETTLE=0
  logic       start_b, abort_b;
  logic [2:0] op_b;
  logic [2:0] din_b;
  logic       dout_b;
  logic       busy_b, done_b, pass_b;
  logic [3:0] err_b;
  logic [2:0] fv_b;

  // gate model selector for instance A: 0 AND, 1 stuck-at-0, 2 XOR, 3 inverter
  int mode_a = 0;

  gate_exerciser #(.N_IN(2), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .op(op_a),
    .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .fail_vec(fv_a)
  );

  gate_exerciser #(.N_IN(3), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .op(op_b),
    .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .fail_vec(fv_b)
  );

  function automatic logic gate_model(input int mode, input logic [3:0] v);
    case (mode)
      0:       return v[0] & v[1];
      1:       return 1'b0;
      2:       return v[0] ^ v[1];
      default: return ~v[0];
    endcase
  endfunction

  always_comb dout_a = gate_model(mode_a, {2'b00, din_a});
  always_comb dout_b = ~din_b[0];

  // Reference function over the low n bits of v.
  function automatic logic ref_fn(input logic [2:0] op, input logic [3:0] v, input int n);
    logic [3:0] m;
    logic [3:0] x;
    int         ones;
    m = 4'((1 << n) - 1);
    x = v & m;
    ones = $countones(x);
    case (op)
      3'd0:    return ~x[0];
      3'd1:    return (ones == n);
      3'd2:    return (ones != 0);
      3'd3:    return (ones != n);
      3'd4:    return (ones == 0);
      3'd5:    return (ones % 2) == 1;
      3'd6:    return (ones % 2) == 0;
      default: return x[0];
    endcase
  endfunction

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic [3:0] fv;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full run on instance A (b=0) or B (b=1); the result is predicted and
  // queued at start, then popped and compared when done is seen.
  task automatic run(input bit b, input int mode, input logic [2:0] op, input bit with_abort);
    int   n, hold, nvec, last, e;
    logic fv;
    logic [3:0] fvv;
    bit   seen;
    logic out;
    exp_t ex;
    logic [31:0] c_din, c_done, c_busy, c_pass, c_err, c_fv;
    n    = b ? 3 : 2;
    hold = b ? 1 : 2;
    nvec = 1 << n;
    last = nvec * hold;
    e    = 0;
    fvv  = '0;
    fv   = 1'b0;
    for (int v = 0; v < nvec; v++) begin
      out = b ? ~v[0] : gate_model(mode, 4'(v));
      if (out != ref_fn(op, 4'(v), n)) begin
        if (e == 0) fvv = 4'(v);
        e++;
      end
    end
    ex.pass = (e == 0);
    ex.err  = 5'(e);
    ex.fv   = fvv;
    sb_q.push_back(ex);

    if (b) begin start_b = 1'b1; op_b = op; abort_b = with_abort; end
    else   begin mode_a = mode; start_a = 1'b1; op_a = op; abort_a = with_abort; end
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < last + 6; t++) begin
      if (t > 0) @(negedge clk);
      c_din  = b ? 32'(din_b)  : 32'(din_a);
      c_done = b ? 32'(done_b) : 32'(done_a);
      c_busy = b ? 32'(busy_b) : 32'(busy_a);
      if (t == 0) check("busy_rise", c_busy, 1);
      if (t < last) check("dut_in_step", c_din, 32'(t / hold));
      if (c_done == 1) begin
        c_pass = b ? 32'(pass_b) : 32'(pass_a);
        c_err  = b ? 32'(err_b)  : 32'(err_a);
        c_fv   = b ? 32'(fv_b)   : 32'(fv_a);
        ex = sb_q.pop_front();
        check("done_cycle", t, last);
        check("done_busy", c_busy, 0);
        check("done_dut_in", c_din, 0);
        check("pass", c_pass, 32'(ex.pass));
        check("err_cnt", c_err, 32'(ex.err));
        if (ex.err != 0) check("fail_vec", c_fv, 32'(ex.fv));
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      @(negedge clk);
      check("done_pulse_end", b ? 32'(done_b) : 32'(done_a), 0);
      check("pass_hold", b ? 32'(pass_b) : 32'(pass_a), 32'(ex.pass));
      check("err_hold", b ? 32'(err_b) : 32'(err_a), 32'(ex.err));
    end
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_err"}, err_a, 0);
    check({tag, "_fv"}, fv_a, 0);
    check({tag, "_din"}, din_a, 0);
  endtask

  int n_done;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; op_a = 3'd0;
    start_b = 1'b0; abort_b = 1'b0; op_b = 3'd0;
    repeat (2) @(negedge clk);
    check_a_idle("reset");
    check("reset_b_din", din_b, 0);
    check("reset_b_busy", busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // correct AND gate, op AND
    run(0, 0, 3'd1, 0);
    // stuck-at-0 output, op NOR
    run(0, 1, 3'd4, 0);
    // XOR gate, op XNOR
    run(0, 2, 3'd6, 0);
    // inverter on dut_in[0], op NOT, N_IN=3, SETTLE=0
    run(1, 0, 3'd0, 0);

    // second start while busy is ignored; abort sampled at E0+4
    mode_a = 0; op_a = 3'd1; start_a = 1'b1;
    @(negedge clk);              // after E0
    start_a = 1'b1;              // sampled at E0+1, must be ignored
    @(negedge clk);              // after E0+1
    start_a = 1'b0;
    check("abort_t1_din", din_a, 0);
    @(negedge clk);              // after E0+2
    check("abort_t2_din", din_a, 1);
    @(negedge clk);              // after E0+3
    check("abort_t3_din", din_a, 1);
    abort_a = 1'b1;
    @(negedge clk);              // after E0+4
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_din", din_a, 0);
    check("abort_pass", pass_a, 0);
    check("abort_err", err_a, 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run(0, 0, 3'd1, 0);

    // reset mid-run: XOR gate vs XNOR mismatches from the first sample
    mode_a = 2; op_a = 3'd6; start_a = 1'b1;
    @(negedge clk);              // after E0
    start_a = 1'b0;
    repeat (2) @(negedge clk);   // after E0+2
    check("pre_reset_err", err_a, 1);
    repeat (2) @(negedge clk);   // after E0+4
    rst_n = 1'b0;
    @(negedge clk);              // after E0+5
    rst_n = 1'b1;
    check_a_idle("midrun_reset");
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    check("reset_no_done", n_done, 0);
    run(0, 2, 3'd6, 0);

    // start and abort together in IDLE: start wins
    run(0, 0, 3'd1, 1);
    // stuck-at-0 vs AND: single mismatch at the last vector
    run(0, 1, 3'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
